// File: rtl/pe_dc_unpool.sv
`default_nettype none
// ============================================================================
// Module      : pe_dc_unpool
// Description : Decoder PE. Accumulates D channels of binary XNOR-popcount,
//               binarizes against a threshold and writes the result into the
//               max-unpool position selected by the encoder's pooling index.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_dc_unpool #(
    parameter  int D             = 4,
    parameter  int FH            = 3,
    parameter  int FW            = 3,
    parameter  int POOL_H        = 2,
    parameter  int POOL_W        = 2,
    parameter  int NORMREF_WIDTH = 6,
    localparam int NP            = POOL_H * POOL_W,
    localparam int ACC_W         = $clog2(D * FH * FW + 1),
    localparam int PINDEX_WIDTH  = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FH*FW-1:0]         win_in,
    input  logic [FH*FW-1:0]         weight_in,
    input  logic [PINDEX_WIDTH-1:0]  pindex_in,
    input  logic [NORMREF_WIDTH-1:0] norm_ref,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NP-1:0]            data_out,
    output logic [NP-1:0]            mask_out,
    output logic [ACC_W-1:0]         acc_out,
    output logic                     idx_err
);

    localparam int KN     = FH * FW;
    localparam int PC_W   = $clog2(KN + 1);
    localparam int BEAT_W = (D > 1) ? $clog2(D) : 1;
    localparam int CMP_W  = (ACC_W > NORMREF_WIDTH) ? ACC_W : NORMREF_WIDTH;

    localparam logic [BEAT_W-1:0]     c_last_beat = BEAT_W'(D - 1);
    localparam logic [PINDEX_WIDTH:0] c_np        = (PINDEX_WIDTH + 1)'(NP);

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q,  beat_d;
    logic [ACC_W-1:0]         acc_q,   acc_d;
    logic [PINDEX_WIDTH-1:0]  pidx_q,  pidx_d;
    logic [NORMREF_WIDTH-1:0] nref_q,  nref_d;

    logic [KN-1:0]   w_match;
    logic [PC_W-1:0] w_pc;
    logic            w_bit;
    logic            w_idx_ok;

    always_comb begin
        w_match = ~(win_in ^ weight_in);
        w_pc    = '0;
        for (int k = 0; k < KN; k++) begin
            w_pc = w_pc + PC_W'(w_match[k]);
        end
    end

    // Threshold compare done at the wider of the two widths, both zero-extended.
    assign w_bit    = (CMP_W'(acc_q) >= CMP_W'(nref_q));
    assign w_idx_ok = ({1'b0, pidx_q} < c_np);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        pidx_d  = pidx_q;
        nref_d  = nref_q;
        case (state_q)
            S_ACC: begin
                if (in_valid) begin
                    if (beat_q == '0) begin
                        acc_d  = ACC_W'(w_pc);
                        pidx_d = pindex_in;
                        nref_d = norm_ref;
                    end else begin
                        acc_d = acc_q + ACC_W'(w_pc);
                    end
                    if (beat_q == c_last_beat) begin
                        beat_d  = '0;
                        state_d = S_OUT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_ACC;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = S_ACC;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACC;
            beat_q  <= '0;
            acc_q   <= '0;
            pidx_q  <= '0;
            nref_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            pidx_q  <= pidx_d;
            nref_q  <= nref_d;
        end
    end

    // Outputs are gated by rst so they are defined even before the first edge.
    always_comb begin
        in_ready  = rst || (state_q == S_ACC);
        out_valid = 1'b0;
        data_out  = '0;
        mask_out  = '0;
        acc_out   = '0;
        idx_err   = 1'b0;
        if (!rst && (state_q == S_OUT)) begin
            out_valid = 1'b1;
            acc_out   = acc_q;
            if (w_idx_ok) begin
                data_out = NP'(w_bit) << pidx_q;
                mask_out = NP'(1) << pidx_q;
            end else begin
                idx_err = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_dc_unpool.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_dc_unpool
// Description : Directed self-checking bench for pe_dc_unpool (2x2 and 3x3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_dc_unpool;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_valid9;
    logic       out_ready, out_ready9;
    logic [8:0] win, wt;
    logic [1:0] pidx;
    logic [3:0] pidx9;
    logic [5:0] nref;

    logic       in_ready, out_valid, idx_err;
    logic [3:0] data_o, mask_o;
    logic [5:0] acc_o;
    logic       in_ready9, out_valid9, idx_err9;
    logic [8:0] data9, mask9;
    logic [5:0] acc9;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_dc_unpool u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .win_in(win), .weight_in(wt), .pindex_in(pidx), .norm_ref(nref),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_o),
        .mask_out(mask_o), .acc_out(acc_o), .idx_err(idx_err)
    );

    pe_dc_unpool #(.POOL_H(3), .POOL_W(3)) u_dut9 (
        .clk(clk), .rst(rst), .in_valid(in_valid9), .in_ready(in_ready9),
        .win_in(win), .weight_in(wt), .pindex_in(pidx9), .norm_ref(nref),
        .out_valid(out_valid9), .out_ready(out_ready9), .data_out(data9),
        .mask_out(mask9), .acc_out(acc9), .idx_err(idx_err9)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted beat on the selected DUT (0 = 2x2, 1 = 3x3).
    task automatic beat(input bit sel, input logic [8:0] w, input logic [8:0] k);
        win = w;
        wt  = k;
        if (sel) in_valid9 = 1'b1; else in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        in_valid9 = 1'b0;
    endtask

    task automatic drain();
        out_ready  = 1'b1;
        out_ready9 = 1'b1;
        step();
        out_ready  = 1'b0;
        out_ready9 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid9 = 1'b0;
        out_ready = 1'b0; out_ready9 = 1'b0;
        win = '0; wt = '0; pidx = '0; pidx9 = '0; nref = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        step(); step();
        chk("rst_data", data_o, 0);
        chk("rst_mask", mask_o, 0);
        chk("rst_acc", acc_o, 0);
        chk("rst_idx_err", idx_err, 0);
        rst = 1'b0;
        step();

        // All-match beats: 4 x 9 = 36 >= 20
        pidx = 2'd2; nref = 6'd20;
        beat(0, 9'h1FF, 9'h1FF);
        pidx = 2'd0; nref = 6'd0;
        beat(0, 9'h1FF, 9'h1FF);
        beat(0, 9'h1FF, 9'h1FF);
        chk("t1_not_yet_valid", out_valid, 0);
        beat(0, 9'h1FF, 9'h1FF);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_acc", acc_o, 36);
        chk("t1_data", data_o, 4'b0100);
        chk("t1_mask", mask_o, 4'b0100);
        chk("t1_idx_err", idx_err, 0);
        drain();
        chk("t1_after_valid", out_valid, 0);
        chk("t1_after_ready", in_ready, 1);
        chk("t1_after_data", data_o, 0);

        // No matches: acc 0; threshold 0 passes, threshold 1 fails
        pidx = 2'd3; nref = 6'd0;
        for (int i = 0; i < 4; i++) beat(0, 9'h000, 9'h1FF);
        chk("t2a_acc", acc_o, 0);
        chk("t2a_data", data_o, 4'b1000);
        chk("t2a_mask", mask_o, 4'b1000);
        drain();
        nref = 6'd1;
        for (int i = 0; i < 4; i++) beat(0, 9'h000, 9'h1FF);
        chk("t2b_data", data_o, 4'b0000);
        chk("t2b_mask", mask_o, 4'b1000);
        drain();

        // Popcounts 9,0,5,3 with idle gaps; later pindex/norm_ref ignored
        pidx = 2'd1; nref = 6'd17;
        beat(0, 9'h1FF, 9'h1FF);
        pidx = 2'd3; nref = 6'd0;
        step();
        beat(0, 9'h1FF, 9'h000);
        step(); step();
        beat(0, 9'h1FF, 9'h01F);
        step(); step(); step();
        chk("t3_gap_no_valid", out_valid, 0);
        beat(0, 9'h1FF, 9'h007);
        chk("t3_acc", acc_o, 17);
        chk("t3_data", data_o, 4'b0010);
        chk("t3_mask", mask_o, 4'b0010);

        // Backpressure: offered beats must not be consumed while stalled
        win = 9'h1FF; wt = 9'h1FF; pidx = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_ready", in_ready, 0);
            chk("t4_stall_data", data_o, 4'b0010);
            chk("t4_stall_acc", acc_o, 17);
        end
        in_valid = 1'b0;
        drain();
        chk("t4_release_ready", in_ready, 1);
        chk("t4_release_valid", out_valid, 0);

        // Reset mid-group discards the partial sum and beat count
        pidx = 2'd2; nref = 6'd0;
        beat(0, 9'h1FF, 9'h1FF);
        beat(0, 9'h1FF, 9'h1FF);
        rst = 1'b1;
        step();
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_valid", out_valid, 0);
        rst = 1'b0;
        pidx = 2'd0; nref = 6'd4;
        for (int i = 0; i < 3; i++) beat(0, 9'h1FF, 9'h001);
        chk("t5_partial_no_valid", out_valid, 0);
        beat(0, 9'h1FF, 9'h001);
        chk("t5_valid", out_valid, 1);
        chk("t5_acc", acc_o, 4);
        chk("t5_data", data_o, 4'b0001);
        chk("t5_mask", mask_o, 4'b0001);
        drain();

        // 3x3 pool: out-of-range index, then the top position
        pidx9 = 4'd10; nref = 6'd0;
        for (int i = 0; i < 4; i++) beat(1, 9'h1FF, 9'h003);
        chk("t6_valid", out_valid9, 1);
        chk("t6_acc", acc9, 8);
        chk("t6_idx_err", idx_err9, 1);
        chk("t6_data", data9, 0);
        chk("t6_mask", mask9, 0);
        drain();
        pidx9 = 4'd8;
        for (int i = 0; i < 4; i++) beat(1, 9'h1FF, 9'h003);
        chk("t7_idx_err", idx_err9, 0);
        chk("t7_mask", mask9, 9'b1_0000_0000);
        chk("t7_data", data9, 9'b1_0000_0000);
        drain();
        chk("t7_after_ready", in_ready9, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_dc_unpool.md
PE_DC_UNPOOL -- requirements
Module: pe_dc_unpool

Interface
- REQ-001: Parameter D, default 4: input channels accumulated per output, one channel per beat.
- REQ-002: Parameter FH, default 3: kernel height.
- REQ-003: Parameter FW, default 3: kernel width.
- REQ-004: Parameter POOL_H, default 2: unpool region height.
- REQ-005: Parameter POOL_W, default 2: unpool region width.
- REQ-006: Parameter NORMREF_WIDTH, default 6: threshold width.
- REQ-007: Derived widths: ACC_W = clog2(D*FH*FW+1); PINDEX_WIDTH = clog2(POOL_H*POOL_W); NP = POOL_H*POOL_W.
- REQ-008: clk  in  1  single clock, all state on rising edge.
- REQ-009: rst  in  1  reset, synchronous, active-high.
- REQ-010: in_valid  in  1  input beat valid.
- REQ-011: in_ready  out  1  block accepts a beat this cycle.
- REQ-012: win_in  in  FH*FW  binary activation window, one channel (1 = +1, 0 = -1).
- REQ-013: weight_in  in  FH*FW  binary kernel slice for the same channel.
- REQ-014: pindex_in  in  PINDEX_WIDTH  pooling index from the encoder PE, sampled on the first beat of a group.
- REQ-015: norm_ref  in  NORMREF_WIDTH  binarization threshold, sampled on the first beat of a group.
- REQ-016: out_valid  out  1  result valid.
- REQ-017: out_ready  in  1  downstream accepts the result.
- REQ-018: data_out  out  NP  unpooled binary result, row-major, bit index = pindex.
- REQ-019: mask_out  out  NP  one-hot position of the restored value.
- REQ-020: acc_out  out  ACC_W  accumulated XNOR-popcount.
- REQ-021: idx_err  out  1  captured pindex >= NP.

Function
- REQ-022: The block has two states: ACC (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
- REQ-023: A beat is accepted when in_valid && in_ready; beat count runs 0..D-1.
- REQ-024: Each accepted beat adds popcount(~(win_in ^ weight_in)) (range 0..FH*FW) to the accumulator.
- REQ-025: On beat 0 the accumulator loads the beat popcount without adding, and pindex_in and norm_ref are registered.
- REQ-026: Cycles with in_valid=0 in ACC change no state, so input gaps are allowed.
- REQ-027: Acceptance of beat D-1 moves the block to OUT on the next edge; out_valid is high the cycle after the last beat (latency 1).
- REQ-028: In OUT: bit = (acc >= norm_ref) unsigned, with norm_ref zero-extended or compared at max(ACC_W, NORMREF_WIDTH) bits.
- REQ-029: In OUT with pindex < NP: data_out[pindex] = bit and other bits 0; mask_out[pindex] = 1 and other bits 0; idx_err = 0.
- REQ-030: In OUT with pindex >= NP: data_out = 0, mask_out = 0, idx_err = 1.
- REQ-031: acc_out holds the final sum.
- REQ-032: All outputs stay stable while out_valid && !out_ready.
- REQ-033: On out_valid && out_ready the block returns to ACC with beat count 0; there is no same-cycle input bypass, so minimum throughput is one result per D+1 cycles.
- REQ-034: In ACC, data_out, mask_out, acc_out and idx_err are 0.
- REQ-035: The accumulator does not overflow: D*FH*FW fits in ACC_W.

Reset
- REQ-036: With rst high at an edge: state = ACC, beat count = 0, accumulator = 0, captured pindex/norm_ref = 0.
- REQ-037: Outputs while rst is high: in_ready = 1, out_valid = 0, data_out = 0, mask_out = 0, acc_out = 0, idx_err = 0.
- REQ-038: rst has priority over any simultaneous handshake.
- REQ-039: A partial group in progress at reset is discarded.

Verification
- REQ-040: Defaults; 4 beats win=9'h1FF, weight=9'h1FF, pindex=2, norm_ref=20 -> one cycle after beat 4: out_valid=1, acc_out=36, data_out=4'b0100, mask_out=4'b0100.
- REQ-041: 4 beats win=9'h000, weight=9'h1FF, pindex=3: norm_ref=0 -> acc_out=0, data_out=4'b1000; repeat with norm_ref=1 -> data_out=4'b0000, mask_out=4'b1000.
- REQ-042: Mixed beats with popcounts 9,0,5,3 and in_valid gaps of 1-3 cycles, norm_ref=17 -> acc_out=17, bit=1; pindex on non-first beats is ignored.
- REQ-043: Backpressure: hold out_ready=0 for 5 cycles -> out_valid, data_out and acc_out stable, in_ready=0 and in_valid beats not consumed; out_ready=1 -> in_ready=1 next cycle.
- REQ-044: Assert rst after 2 beats (acc=18), then send 4 fresh beats of popcount 1 -> acc_out=4, with no residue from the aborted group.
- REQ-045: POOL_H=POOL_W=3 (PINDEX_WIDTH=4), pindex=10 -> idx_err=1, data_out=0, mask_out=0; pindex=8 -> mask_out=9'b1_0000_0000.
